// File: rtl/arctos_pkg.sv
// Arctos32 shared definitions: ALU opcodes, instruction field
// positions and the issue-controller state encoding.
package arctos_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_MUL   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_NOT   = 4'h5,
        OP_NOR   = 4'h6,
        OP_NAND  = 4'h7,
        OP_XOR   = 4'h8,
        OP_XNOR  = 4'h9,
        OP_INC   = 4'hA,
        OP_DEC   = 4'hB,
        OP_SHL   = 4'hC,
        OP_SHR   = 4'hD,
        OP_RSV_E = 4'hE,
        OP_RSV_F = 4'hF
    } alu_op_e;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 4;
    localparam int REG_W   = 5;
    localparam int OPC_LSB = 28;
    localparam int SRC_BIT = 27;
    localparam int RD_LSB  = 22;
    localparam int RS1_LSB = 17;
    localparam int RS2_LSB = 12;
    localparam int IMM_W   = 17;
    localparam int SHAMT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB_LO,
        ST_WB_HI
    } issue_state_e;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational field split of a latched Arctos32 ALU instruction.
// Unused fields are passed through; the ALU ignores them.
module alu_instr_decode
    import arctos_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr_i,
    output alu_op_e            opcode_o,
    output logic               src_sel_o,
    output logic [REG_W-1:0]   rd_o,
    output logic [REG_W-1:0]   rs1_o,
    output logic [REG_W-1:0]   rs2_o,
    output logic [XLEN-1:0]    imm_o,
    output logic [XLEN-1:0]    shamt_o,
    output logic               is_mul_o,
    output logic               is_illegal_o
);

    assign opcode_o  = alu_op_e'(instr_i[OPC_LSB +: OPC_W]);
    assign src_sel_o = instr_i[SRC_BIT];
    assign rd_o      = instr_i[RD_LSB +: REG_W];
    assign rs1_o     = instr_i[RS1_LSB +: REG_W];
    assign rs2_o     = instr_i[RS2_LSB +: REG_W];
    assign imm_o     = {{(XLEN-IMM_W){instr_i[IMM_W-1]}},
                        instr_i[IMM_W-1:0]};
    assign shamt_o   = {{(XLEN-SHAMT_W){1'b0}},
                        instr_i[SHAMT_W-1:0]};

    assign is_mul_o     = (opcode_o == OP_MUL);
    assign is_illegal_o = (opcode_o == OP_RSV_E) ||
                          (opcode_o == OP_RSV_F);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Arctos32 ALU issue controller: read operands, run the ALU for one
// cycle, write back one word (two for MUL) and retire.
module alu_issue_ctrl
    import arctos_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [AW-1:0]     rf_raddr_a,
    output logic [AW-1:0]     rf_raddr_b,
    input  logic [XLEN-1:0]   rf_rdata_a,
    input  logic [XLEN-1:0]   rf_rdata_b,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              alu_enable,
    output logic [3:0]        alu_opcode,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic              alu_src_sel,
    output logic [XLEN-1:0]   alu_shift_amt,
    output logic [XLEN-1:0]   alu_imm,
    input  logic [2*XLEN-1:0] alu_result,
    input  logic              alu_z,
    input  logic              alu_carry,
    output logic              flag_z,
    output logic              flag_c,
    output logic              illegal,
    output logic              done
);

    issue_state_e        state_q, state_d;
    logic                live_q;
    logic [31:0]         instr_q, instr_d;
    logic [XLEN-1:0]     opa_q, opa_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2*XLEN-1:0]   res_q, res_d;
    logic                fz_q, fz_d;
    logic                fc_q, fc_d;

    alu_op_e             dec_op;
    logic                dec_src;
    logic [REG_W-1:0]    dec_rd, dec_rs1, dec_rs2;
    logic [XLEN-1:0]     dec_imm, dec_shamt;
    logic                dec_mul, dec_ill;
    logic [AW-1:0]       rd_lo, rd_hi;

    alu_instr_decode #(.XLEN(XLEN)) u_dec (
        .instr_i      (instr_q),
        .opcode_o     (dec_op),
        .src_sel_o    (dec_src),
        .rd_o         (dec_rd),
        .rs1_o        (dec_rs1),
        .rs2_o        (dec_rs2),
        .imm_o        (dec_imm),
        .shamt_o      (dec_shamt),
        .is_mul_o     (dec_mul),
        .is_illegal_o (dec_ill)
    );

    // MUL high word goes to rd+1, wrapping 31 onto r0
    assign rd_lo  = dec_rd[AW-1:0];
    assign rd_hi  = rd_lo + AW'(1);
    assign flag_z = fz_q;
    assign flag_c = fc_q;

    // State and datapath registers; live_q holds ready low until
    // the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            live_q  <= 1'b0;
            instr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            instr_q <= instr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
        end
    end

    // Next state, register loads and per-state port drive
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        res_d         = res_q;
        fz_d          = fz_q;
        fc_d          = fc_q;
        instr_ready   = 1'b0;
        rf_raddr_a    = '0;
        rf_raddr_b    = '0;
        rf_we         = 1'b0;
        rf_waddr      = '0;
        rf_wdata      = '0;
        alu_enable    = 1'b0;
        alu_opcode    = '0;
        alu_a         = '0;
        alu_b         = '0;
        alu_src_sel   = 1'b0;
        alu_shift_amt = '0;
        alu_imm       = '0;
        illegal       = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                instr_ready = live_q;
                if (instr_valid && live_q) begin
                    instr_d = instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                rf_raddr_a = dec_rs1[AW-1:0];
                rf_raddr_b = dec_rs2[AW-1:0];
                opa_d      = rf_rdata_a;
                opb_d      = rf_rdata_b;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                alu_enable    = 1'b1;
                alu_opcode    = dec_op;
                alu_a         = opa_q;
                alu_b         = opb_q;
                alu_src_sel   = dec_src;
                alu_shift_amt = dec_shamt;
                alu_imm       = dec_imm;
                res_d         = alu_result;
                if (!dec_ill) begin
                    fz_d = alu_z;
                    fc_d = alu_carry;
                end
                state_d = ST_WB_LO;
            end
            ST_WB_LO: begin
                if (dec_ill) begin
                    illegal = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    rf_we    = (rd_lo != '0);
                    rf_waddr = rd_lo;
                    rf_wdata = res_q[XLEN-1:0];
                    done     = !dec_mul;
                    state_d  = dec_mul ? ST_WB_HI : ST_IDLE;
                end
            end
            ST_WB_HI: begin
                rf_we    = (rd_hi != '0);
                rf_waddr = rd_hi;
                rf_wdata = res_q[2*XLEN-1:XLEN];
                done     = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
